timed_bank_scheduler: RTL and testbench



---
 rtl/timed_bank_scheduler_pkg.sv | 13 +
 rtl/timed_bank_scheduler_rr_pick4.sv | 26 ++
 rtl/timed_bank_scheduler.sv | 135 +++++++++++++
 tb/tb_timed_bank_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/timed_bank_scheduler_pkg.sv
// Shared types and sizing for the timed bank scheduler.
package arb_pkg;

   localparam int unsigned NUM_GROUPS      = 4;
   localparam int unsigned BANKS_PER_GROUP = 4;
   localparam int unsigned NUM_BANKS       = 16;

   typedef enum logic {EMPTY, FULL} out_state_t;

   typedef logic [3:0] bank_idx_t;
   typedef logic [1:0] grp_idx_t;

endpackage

// File: rtl/timed_bank_scheduler_rr_pick4.sv
// Combinational 4-way round-robin picker: search starts one past the last pointer.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [3:0] i_req,
   input  grp_idx_t   i_last,
   output logic       o_found,
   output grp_idx_t   o_idx
);

   grp_idx_t w_cand;

   always_comb begin
      o_found = 1'b0;
      o_idx   = i_last;
      w_cand  = i_last;
      for (int unsigned k = 1; k <= 4; k++) begin
         w_cand = grp_idx_t'(i_last + grp_idx_t'(k));
         if (!o_found && i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/timed_bank_scheduler.sv
// Timing-aware 16-bank scheduler: tCCD_L/tCCD_S spacing, two-level round-robin,
// registered ready/valid output stage.
module timed_bank_scheduler
   import arb_pkg::*;
#(
   parameter int unsigned REQ_SIZE = 32,
   parameter int unsigned TCCD_L   = 4,
   parameter int unsigned TCCD_S   = 2
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_BANKS-1:0]          req,
   input  logic [NUM_BANKS-1:0]          valid,
   input  logic [NUM_BANKS*REQ_SIZE-1:0] data_in,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [REQ_SIZE-1:0]           data_out,
   output logic [3:0]                    grant_idx,
   output logic [NUM_BANKS-1:0]          ack
);

   localparam int unsigned CW = $clog2(TCCD_L) + 1;
   typedef logic [CW-1:0] cnt_t;

   out_state_t          r_state;
   out_state_t          w_state_next;

   cnt_t                r_scnt;
   cnt_t                r_lcnt [NUM_GROUPS];
   grp_idx_t            r_gptr;
   grp_idx_t            r_bptr [NUM_GROUPS];

   logic [REQ_SIZE-1:0] r_data;
   bank_idx_t           r_grant;
   logic [NUM_BANKS-1:0] r_ack;

   logic [NUM_BANKS-1:0] w_elig;
   logic [3:0]          w_grp_req;
   logic [3:0]          w_bank_found;
   grp_idx_t            w_bank_idx [NUM_GROUPS];
   logic                w_grp_found;
   grp_idx_t            w_grp_idx;
   grp_idx_t            w_sel_bank;
   bank_idx_t           w_sel_idx;
   logic [REQ_SIZE-1:0] w_sel_word;
   logic                w_issue;

   // The just-acked bank is masked so it cannot win again before its source advances
   assign w_elig = req & valid & ~r_ack;

   for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_bank_pick
      assign w_grp_req[gi] = (|w_elig[gi*BANKS_PER_GROUP +: BANKS_PER_GROUP]) && (r_lcnt[gi] == '0);

      rr_pick4 u_bank_pick (
         .i_req   (w_elig[gi*BANKS_PER_GROUP +: BANKS_PER_GROUP]),
         .i_last  (r_bptr[gi]),
         .o_found (w_bank_found[gi]),
         .o_idx   (w_bank_idx[gi])
      );
   end

   rr_pick4 u_grp_pick (
      .i_req   (w_grp_req),
      .i_last  (r_gptr),
      .o_found (w_grp_found),
      .o_idx   (w_grp_idx)
   );

   assign w_sel_bank = w_bank_idx[w_grp_idx];
   assign w_sel_idx  = {w_grp_idx, w_sel_bank};
   assign w_sel_word = data_in[w_sel_idx*REQ_SIZE +: REQ_SIZE];
   assign w_issue    = (r_scnt == '0) && w_grp_found && (!out_valid || out_ready);

   // Spacing counters keep running during output stalls; an issue reload wins over decrement
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scnt <= '0;
         for (int unsigned g = 0; g < NUM_GROUPS; g++) r_lcnt[g] <= '0;
      end else begin
         if (w_issue)            r_scnt <= cnt_t'(TCCD_S - 1);
         else if (r_scnt != '0)  r_scnt <= r_scnt - cnt_t'(1);
         for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            if (w_issue && (w_grp_idx == grp_idx_t'(g))) r_lcnt[g] <= cnt_t'(TCCD_L - 1);
            else if (r_lcnt[g] != '0)                   r_lcnt[g] <= r_lcnt[g] - cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gptr <= '1;
         for (int unsigned g = 0; g < NUM_GROUPS; g++) r_bptr[g] <= '1;
      end else if (w_issue) begin
         r_gptr            <= w_grp_idx;
         r_bptr[w_grp_idx] <= w_sel_bank;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_grant <= '0;
         r_ack   <= '0;
      end else if (w_issue) begin
         r_data  <= w_sel_word;
         r_grant <= w_sel_idx;
         r_ack   <= NUM_BANKS'(1) << w_sel_idx;
      end else begin
         r_ack   <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= EMPTY;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         EMPTY:   if (w_issue) w_state_next = FULL;
         FULL:    if (out_ready && !w_issue) w_state_next = EMPTY;
         default: w_state_next = EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (r_state == FULL);
   end

   assign data_out  = r_data;
   assign grant_idx = r_grant;
   assign ack       = r_ack;

endmodule

// File: tb/tb_timed_bank_scheduler.sv
// Bench for timed_bank_scheduler: two instances (4/2 and 1/1 spacing) against a time-stamp reference model.
module tb_timed_bank_scheduler;

   localparam int RS = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [15:0]       req;
   logic [15:0]       valid;
   logic [16*RS-1:0]  data_in;
   logic              out_ready;

   logic              ov_o   [2];
   logic [RS-1:0]     dout_o [2];
   logic [3:0]        gidx_o [2];
   logic [15:0]       ack_o  [2];

   int                n_tests = 0;
   int                n_fail  = 0;

   // Reference state: spacing is judged from edge time-stamps of earlier issues
   int                t;
   int                m_L [2] = '{4, 1};
   int                m_S [2] = '{2, 1};
   int                m_last_any [2];
   int                m_last_grp [2][4];
   int                m_gptr [2];
   int                m_bptr [2][4];
   logic              m_ov   [2];
   logic [RS-1:0]     m_dout [2];
   int                m_gidx [2];
   logic [15:0]       m_ack  [2];

   always #5 clk = ~clk;

   timed_bank_scheduler #(.REQ_SIZE(RS), .TCCD_L(4), .TCCD_S(2)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .valid     (valid),
      .data_in   (data_in),
      .out_ready (out_ready),
      .out_valid (ov_o[0]),
      .data_out  (dout_o[0]),
      .grant_idx (gidx_o[0]),
      .ack       (ack_o[0])
   );

   timed_bank_scheduler #(.REQ_SIZE(RS), .TCCD_L(1), .TCCD_S(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .valid     (valid),
      .data_in   (data_in),
      .out_ready (out_ready),
      .out_valid (ov_o[1]),
      .data_out  (dout_o[1]),
      .grant_idx (gidx_o[1]),
      .ack       (ack_o[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_last_any[d] = -100;
         for (int g = 0; g < 4; g++) begin
            m_last_grp[d][g] = -100;
            m_bptr[d][g]     = 3;
         end
         m_gptr[d] = 3;
         m_ov[d]   = 1'b0;
         m_dout[d] = '0;
         m_gidx[d] = 0;
         m_ack[d]  = '0;
      end
   endtask

   task automatic model_edge();
      logic [15:0] elig;
      bit          found;
      int          sg, sb, idx, g, b;
      t++;
      for (int d = 0; d < 2; d++) begin
         elig  = req & valid & ~m_ack[d];
         found = 0;
         sg    = 0;
         sb    = 0;
         if ((!m_ov[d] || out_ready) && (t - m_last_any[d] >= m_S[d])) begin
            for (int k = 1; k <= 4; k++) begin
               g = (m_gptr[d] + k) % 4;
               if (!found && (t - m_last_grp[d][g] >= m_L[d]) && (((elig >> (4*g)) & 16'hF) != 0)) begin
                  for (int j = 1; j <= 4; j++) begin
                     b = (m_bptr[d][g] + j) % 4;
                     if (!found && elig[4*g+b]) begin
                        found = 1;
                        sg    = g;
                        sb    = b;
                     end
                  end
               end
            end
         end
         if (found) begin
            idx               = 4*sg + sb;
            m_dout[d]         = data_in[idx*RS +: RS];
            m_gidx[d]         = idx;
            m_ov[d]           = 1'b1;
            m_ack[d]          = 16'(1) << idx;
            m_gptr[d]         = sg;
            m_bptr[d][sg]     = sb;
            m_last_any[d]     = t;
            m_last_grp[d][sg] = t;
         end else begin
            m_ack[d] = '0;
            if (out_ready) m_ov[d] = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("u%0d_out_valid", d), 32'(ov_o[d]),   32'(m_ov[d]));
         chk($sformatf("u%0d_ack", d),       32'(ack_o[d]),  32'(m_ack[d]));
         chk($sformatf("u%0d_grant_idx", d), 32'(gidx_o[d]), 32'(m_gidx[d]));
         chk($sformatf("u%0d_data_out", d),  32'(dout_o[d]), 32'(m_dout[d]));
      end
   endtask

   task automatic rand_data();
      for (int i = 0; i < 16; i++) data_in[i*RS +: RS] = $urandom;
   endtask

   task automatic step();
      if (rst_n) model_edge();
      else       t++;
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      t         = 0;
      rst_n     = 1'b0;
      req       = '0;
      valid     = '0;
      out_ready = 1'b1;
      rand_data();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("u%0d_rst_out_valid", d), 32'(ov_o[d]),   32'd0);
         chk($sformatf("u%0d_rst_ack", d),       32'(ack_o[d]),  32'd0);
         chk($sformatf("u%0d_rst_grant", d),     32'(gidx_o[d]), 32'd0);
         chk($sformatf("u%0d_rst_data", d),      32'(dout_o[d]), 32'd0);
      end

      // All banks requesting: group-interleaved grants
      req   = 16'hFFFF;
      valid = 16'hFFFF;
      step();
      chk("u0_first_grant", 32'(gidx_o[0]), 32'd0);
      repeat (24) begin rand_data(); step(); end

      // Single group: same-group spacing governs
      req   = 16'h000F;
      valid = 16'h000F;
      repeat (20) begin rand_data(); step(); end

      // Output stall on bank 5, then refill
      req   = 16'h0020;
      valid = 16'h0020;
      repeat (4) begin rand_data(); step(); end
      out_ready = 1'b0;
      repeat (6) begin rand_data(); step(); end
      out_ready = 1'b1;
      repeat (8) begin rand_data(); step(); end

      // Bank 9 requests without valid data
      req   = 16'h0204;
      valid = 16'h0004;
      repeat (12) begin rand_data(); step(); end
      valid = 16'h0204;
      repeat (8) begin rand_data(); step(); end

      // Random traffic with random back-pressure
      repeat (300) begin
         rand_data();
         req       = 16'($urandom);
         valid     = 16'($urandom) | 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Asynchronous reset mid-operation
      out_ready = 1'b1;
      req       = 16'hFFFF;
      valid     = 16'hFFFF;
      repeat (3) begin rand_data(); step(); end
      #1;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("u%0d_async_out_valid", d), 32'(ov_o[d]),  32'd0);
         chk($sformatf("u%0d_async_ack", d),       32'(ack_o[d]), 32'd0);
         chk($sformatf("u%0d_async_data", d),      32'(dout_o[d]), 32'd0);
      end
      model_reset();
      step();
      rst_n = 1'b1;
      req   = 16'h00F6;
      valid = 16'h00F6;
      step();
      chk("u0_post_reset_grant", 32'(gidx_o[0]), 32'd1);
      repeat (10) begin rand_data(); step(); end

      // Banks 3 and 7 alternating
      req   = 16'h0088;
      valid = 16'h0088;
      repeat (12) begin rand_data(); step(); end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
